alu_wb_retire_buffer: RTL and testbench
=======================================

// Module: alu_wb_retire_buffer
// PURPOSE
//  Writeback-side consumer of the ALU EX->WB pipeline flops. Queues completed ALU ops, drives
//  VGPR/SGPR register-file write-port requests with req/gnt handshake, and emits one in-order
//  retire pulse (wfid, pc) per op once all its writes are granted. Gives the ALU backpressure.
// PARAMETERS
//  DEPTH   4  queue entries; power of two, >= 2
//  PTR_W   2  log2(DEPTH); read/write pointer width
// PORTS
//  clk                 in   1   clock; all state on rising edge
//  rst                 in   1   asynchronous, active-low reset
//  in_wfid             in   6   wavefront id of completing op
//  in_instr_pc         in   32  pc of completing op
//  in_vgpr_dest_addr   in   10  VGPR destination
//  in_sgpr_dest_addr   in   9   SGPR destination
//  in_instr_done       in   1   push strobe: op completes this cycle
//  in_vgpr_wr_en       in   1   op writes a VGPR
//  in_sgpr_wr_en       in   1   op writes an SGPR
//  in_vcc_wr_en        in   1   op writes VCC (shares SGPR port)
//  in_vgpr_wr_gnt      in   1   VGPR write port grant
//  in_sgpr_wr_gnt      in   1   SGPR write port grant
//  out_vgpr_wr_req     out  1   VGPR write request for head entry
//  out_vgpr_wr_addr    out  10  head VGPR destination
//  out_sgpr_wr_req     out  1   SGPR/VCC write request for head entry
//  out_sgpr_wr_addr    out  9   head SGPR destination
//  out_sgpr_wr_vcc     out  1   head SGPR-port write includes VCC
//  out_wr_wfid         out  6   head wfid, qualifies both requests
//  out_retire_valid    out  1   one-cycle retire pulse for head
//  out_retire_wfid     out  6   retiring wfid
//  out_retire_pc       out  32  retiring pc
//  out_alu_stall       out  1   ALU must not launch new ops
//  out_overflow        out  1   sticky error: push dropped
//  out_perf_stall_cnt  out  32  stall-cycle counter (optional feature)
//  out_perf_retire_cnt out  32  retired-op counter (optional feature)
// BEHAVIOUR
//  - Reset (rst=0, async): pointers, count, all entry flags, out_overflow, perf counters = 0;
//    every output 0. Reset mid-handshake discards all entries; no retire pulse follows.
//  - Push: in_instr_done=1 at edge writes entry {wfid,pc,vaddr,saddr,vpend=vgpr_wr_en,
//    spend=sgpr_wr_en|vcc_wr_en, vcc=vcc_wr_en}. Wr_en bits ignored when in_instr_done=0.
//  - Push accepted if count<DEPTH, or count==DEPTH and head pops same cycle; else dropped,
//    out_overflow set (cleared only by reset).
//  - Requests (combinational from head regs): out_vgpr_wr_req = head_valid & vpend;
//    out_sgpr_wr_req = head_valid & spend. Addr/wfid/vcc held stable while req high.
//  - Grant while req high clears that pend flag at edge; grant with req low ignored.
//    Both ports may be granted same cycle.
//  - Retire: head_valid & !vpend & !spend -> out_retire_valid=1 that cycle, pop at edge.
//    Pending flags of head are evaluated post-grant within cycle: if the last outstanding
//    grant arrives in cycle N, retire pulses in N+1. Op with no writes: pushed edge N,
//    retires in cycle N+1 (min latency 1). At most one retire per cycle; strictly in order.
//  - out_alu_stall = (count >= DEPTH-1), combinational from registered count. ALU contract:
//    at most one push after stall asserts (op already in EX->WB flops).
//  - Pointers wrap modulo DEPTH; count width PTR_W+1. Push+pop same cycle: count unchanged.
// CONFIGURATION
//  ALU_WB_RETIRE_PERF_EN defined: out_perf_stall_cnt +1 each cycle out_alu_stall=1;
//   out_perf_retire_cnt +1 each out_retire_valid; both 32-bit, wrap 0xFFFFFFFF->0.
//  Undefined: counters not built, both ports tied to 0; all other behaviour identical.
// TESTING
//  1 Push wfid=5,pc=0x100,vgpr_wr_en=1,vaddr=0x12; gnt held 0 3 cycles then 1 -> req high
//    with addr 0x12 throughout; retire pulse wfid=5,pc=0x100 cycle after grant.
//  2 Push op with sgpr_wr_en=1,vcc_wr_en=1,vgpr_wr_en=1; grant SGPR then VGPR two cycles later
//    -> out_sgpr_wr_vcc=1; single retire only after VGPR grant.
//  3 Push 4 no-write ops back to back (gnts 0) -> retire pulses pcs in push order, 1/cycle.
//  4 Hold gnts 0, push 3 VGPR ops -> stall=1 after 3rd; 4th push accepted, 5th push
//    -> dropped, out_overflow=1; grant all -> exactly 4 retires.
//  5 Assert rst=0 mid-stream with count=2, req high -> outputs 0 asynchronously; after
//    release no retire, count=0, overflow=0.
//  6 PERF_EN: 10 retires and 3 stall cycles -> retire_cnt=10, stall_cnt=3; undefined -> both 0.

Source files
------------

// File: rtl/alu_wb_retire_buffer.sv
// In-order writeback/retire queue behind the ALU EX->WB flops: issues VGPR/SGPR write requests
// for the head op and retires it once all writes are granted. Optional perf counters: ALU_WB_RETIRE_PERF_EN.
module alu_wb_retire_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  in_wfid,
   input  logic [31:0] in_instr_pc,
   input  logic [9:0]  in_vgpr_dest_addr,
   input  logic [8:0]  in_sgpr_dest_addr,
   input  logic        in_instr_done,
   input  logic        in_vgpr_wr_en,
   input  logic        in_sgpr_wr_en,
   input  logic        in_vcc_wr_en,
   input  logic        in_vgpr_wr_gnt,
   input  logic        in_sgpr_wr_gnt,
   output logic        out_vgpr_wr_req,
   output logic [9:0]  out_vgpr_wr_addr,
   output logic        out_sgpr_wr_req,
   output logic [8:0]  out_sgpr_wr_addr,
   output logic        out_sgpr_wr_vcc,
   output logic [5:0]  out_wr_wfid,
   output logic        out_retire_valid,
   output logic [5:0]  out_retire_wfid,
   output logic [31:0] out_retire_pc,
   output logic        out_alu_stall,
   output logic        out_overflow,
   output logic [31:0] out_perf_stall_cnt,
   output logic [31:0] out_perf_retire_cnt
);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   cnt_t;

   localparam cnt_t FULL_LVL  = cnt_t'(DEPTH);
   localparam cnt_t STALL_LVL = cnt_t'(DEPTH - 1);

   logic [5:0]  wfid_q  [DEPTH];
   logic [31:0] pc_q    [DEPTH];
   logic [9:0]  vaddr_q [DEPTH];
   logic [8:0]  saddr_q [DEPTH];
   logic [DEPTH-1:0] vcc_q;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] vpend_q, vpend_d;
   logic [DEPTH-1:0] spend_q, spend_d;
   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   cnt_t count_q, count_d;
   logic overflow_q, overflow_d;

   logic head_valid, head_vpend, head_spend;
   logic vgpr_req, sgpr_req, retire, push_ok;

   assign head_valid = valid_q[rd_ptr_q];
   assign head_vpend = vpend_q[rd_ptr_q];
   assign head_spend = spend_q[rd_ptr_q];

   assign vgpr_req = head_valid & head_vpend;
   assign sgpr_req = head_valid & head_spend;
   assign retire   = head_valid & ~head_vpend & ~head_spend;

   // A full queue still accepts when the head pops this cycle; the push lands in the freed slot.
   assign push_ok  = in_instr_done & ((count_q < FULL_LVL) | retire);

   always_comb begin
      valid_d    = valid_q;
      vpend_d    = vpend_q;
      spend_d    = spend_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (in_instr_done & ~push_ok);

      if (vgpr_req & in_vgpr_wr_gnt) vpend_d[rd_ptr_q] = 1'b0;
      if (sgpr_req & in_sgpr_wr_gnt) spend_d[rd_ptr_q] = 1'b0;

      if (retire) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + ptr_t'(1);
      end

      if (push_ok) begin
         valid_d[wr_ptr_q] = 1'b1;
         vpend_d[wr_ptr_q] = in_vgpr_wr_en;
         spend_d[wr_ptr_q] = in_sgpr_wr_en | in_vcc_wr_en;
         wr_ptr_d          = wr_ptr_q + ptr_t'(1);
      end

      case ({push_ok, retire})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q    <= '0;
         vpend_q    <= '0;
         spend_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         vpend_q    <= vpend_d;
         spend_q    <= spend_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            wfid_q[i]  <= '0;
            pc_q[i]    <= '0;
            vaddr_q[i] <= '0;
            saddr_q[i] <= '0;
         end
         vcc_q <= '0;
      end else if (push_ok) begin
         wfid_q[wr_ptr_q]  <= in_wfid;
         pc_q[wr_ptr_q]    <= in_instr_pc;
         vaddr_q[wr_ptr_q] <= in_vgpr_dest_addr;
         saddr_q[wr_ptr_q] <= in_sgpr_dest_addr;
         vcc_q[wr_ptr_q]   <= in_vcc_wr_en;
      end
   end

   // Head fields are gated by head_valid so an empty queue presents all-zero outputs.
   assign out_vgpr_wr_req  = vgpr_req;
   assign out_sgpr_wr_req  = sgpr_req;
   assign out_vgpr_wr_addr = head_valid ? vaddr_q[rd_ptr_q] : '0;
   assign out_sgpr_wr_addr = head_valid ? saddr_q[rd_ptr_q] : '0;
   assign out_sgpr_wr_vcc  = head_valid & vcc_q[rd_ptr_q];
   assign out_wr_wfid      = head_valid ? wfid_q[rd_ptr_q] : '0;
   assign out_retire_valid = retire;
   assign out_retire_wfid  = retire ? wfid_q[rd_ptr_q] : '0;
   assign out_retire_pc    = retire ? pc_q[rd_ptr_q] : '0;
   assign out_alu_stall    = (count_q >= STALL_LVL);
   assign out_overflow     = overflow_q;

`ifdef ALU_WB_RETIRE_PERF_EN
   logic [31:0] perf_stall_q, perf_retire_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_q  <= '0;
         perf_retire_q <= '0;
      end else begin
         if (out_alu_stall) perf_stall_q  <= perf_stall_q + 32'd1;
         if (retire)        perf_retire_q <= perf_retire_q + 32'd1;
      end
   end

   assign out_perf_stall_cnt  = perf_stall_q;
   assign out_perf_retire_cnt = perf_retire_q;
`else
   assign out_perf_stall_cnt  = '0;
   assign out_perf_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_wb_retire_buffer.sv
// Directed bench for alu_wb_retire_buffer; perf expectations follow ALU_WB_RETIRE_PERF_EN.
module tb_alu_wb_retire_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  in_wfid;
   logic [31:0] in_instr_pc;
   logic [9:0]  in_vgpr_dest_addr;
   logic [8:0]  in_sgpr_dest_addr;
   logic        in_instr_done, in_vgpr_wr_en, in_sgpr_wr_en, in_vcc_wr_en;
   logic        in_vgpr_wr_gnt, in_sgpr_wr_gnt;
   logic        out_vgpr_wr_req, out_sgpr_wr_req, out_sgpr_wr_vcc;
   logic [9:0]  out_vgpr_wr_addr;
   logic [8:0]  out_sgpr_wr_addr;
   logic [5:0]  out_wr_wfid, out_retire_wfid;
   logic        out_retire_valid, out_alu_stall, out_overflow;
   logic [31:0] out_retire_pc, out_perf_stall_cnt, out_perf_retire_cnt;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] ret_pc [8];
   int nret;

   alu_wb_retire_buffer #(.DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .rst(rst),
      .in_wfid(in_wfid), .in_instr_pc(in_instr_pc),
      .in_vgpr_dest_addr(in_vgpr_dest_addr), .in_sgpr_dest_addr(in_sgpr_dest_addr),
      .in_instr_done(in_instr_done), .in_vgpr_wr_en(in_vgpr_wr_en),
      .in_sgpr_wr_en(in_sgpr_wr_en), .in_vcc_wr_en(in_vcc_wr_en),
      .in_vgpr_wr_gnt(in_vgpr_wr_gnt), .in_sgpr_wr_gnt(in_sgpr_wr_gnt),
      .out_vgpr_wr_req(out_vgpr_wr_req), .out_vgpr_wr_addr(out_vgpr_wr_addr),
      .out_sgpr_wr_req(out_sgpr_wr_req), .out_sgpr_wr_addr(out_sgpr_wr_addr),
      .out_sgpr_wr_vcc(out_sgpr_wr_vcc), .out_wr_wfid(out_wr_wfid),
      .out_retire_valid(out_retire_valid), .out_retire_wfid(out_retire_wfid),
      .out_retire_pc(out_retire_pc), .out_alu_stall(out_alu_stall),
      .out_overflow(out_overflow), .out_perf_stall_cnt(out_perf_stall_cnt),
      .out_perf_retire_cnt(out_perf_retire_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] w, input logic [31:0] pc, input logic [9:0] va,
                       input logic [8:0] sa, input logic v, input logic s, input logic c);
      in_wfid = w; in_instr_pc = pc; in_vgpr_dest_addr = va; in_sgpr_dest_addr = sa;
      in_vgpr_wr_en = v; in_sgpr_wr_en = s; in_vcc_wr_en = c; in_instr_done = 1'b1;
      tick;
      in_instr_done = 1'b0; in_vgpr_wr_en = 1'b0; in_sgpr_wr_en = 1'b0; in_vcc_wr_en = 1'b0;
   endtask

   task automatic drain(input int cycles, output int n);
      n = 0;
      in_vgpr_wr_gnt = 1'b1; in_sgpr_wr_gnt = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         if (out_retire_valid) begin
            if (n < 8) ret_pc[n] = out_retire_pc;
            n++;
         end
         tick;
      end
      in_vgpr_wr_gnt = 1'b0; in_sgpr_wr_gnt = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      tick; tick;
      rst = 1'b1;
      tick;
   endtask

   initial begin
      rst = 1'b0;
      in_wfid = '0; in_instr_pc = '0; in_vgpr_dest_addr = '0; in_sgpr_dest_addr = '0;
      in_instr_done = 1'b0; in_vgpr_wr_en = 1'b0; in_sgpr_wr_en = 1'b0; in_vcc_wr_en = 1'b0;
      in_vgpr_wr_gnt = 1'b0; in_sgpr_wr_gnt = 1'b0;
      tick; tick;
      chk("rst_vreq", out_vgpr_wr_req, 0);
      chk("rst_sreq", out_sgpr_wr_req, 0);
      chk("rst_retire", out_retire_valid, 0);
      chk("rst_stall", out_alu_stall, 0);
      chk("rst_ovf", out_overflow, 0);
      chk("rst_perf_s", out_perf_stall_cnt, 0);
      rst = 1'b1;
      tick;

      // 1: single VGPR op, grant delayed 3 cycles
      push(6'd5, 32'h100, 10'h12, 9'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("t1_vreq", out_vgpr_wr_req, 1);
         chk("t1_vaddr", out_vgpr_wr_addr, 10'h12);
         chk("t1_wfid", out_wr_wfid, 5);
         chk("t1_noret", out_retire_valid, 0);
         tick;
      end
      chk("t1_vreq3", out_vgpr_wr_req, 1);
      in_vgpr_wr_gnt = 1'b1;
      tick;
      in_vgpr_wr_gnt = 1'b0;
      chk("t1_vreq_off", out_vgpr_wr_req, 0);
      chk("t1_ret", out_retire_valid, 1);
      chk("t1_ret_wfid", out_retire_wfid, 5);
      chk("t1_ret_pc", out_retire_pc, 32'h100);
      tick;
      chk("t1_ret_once", out_retire_valid, 0);

      // 2: VGPR+SGPR+VCC op, SGPR granted first, VGPR two cycles later
      push(6'd9, 32'h200, 10'h3FF, 9'h1A5, 1'b1, 1'b1, 1'b1);
      chk("t2_sreq", out_sgpr_wr_req, 1);
      chk("t2_vcc", out_sgpr_wr_vcc, 1);
      chk("t2_saddr", out_sgpr_wr_addr, 9'h1A5);
      chk("t2_vreq", out_vgpr_wr_req, 1);
      in_sgpr_wr_gnt = 1'b1;
      tick;
      in_sgpr_wr_gnt = 1'b0;
      chk("t2_sreq_off", out_sgpr_wr_req, 0);
      chk("t2_vreq_hold", out_vgpr_wr_req, 1);
      chk("t2_noret_a", out_retire_valid, 0);
      tick;
      chk("t2_noret_b", out_retire_valid, 0);
      in_vgpr_wr_gnt = 1'b1;
      tick;
      in_vgpr_wr_gnt = 1'b0;
      chk("t2_ret", out_retire_valid, 1);
      chk("t2_ret_pc", out_retire_pc, 32'h200);
      tick;
      chk("t2_ret_once", out_retire_valid, 0);

      // 3: four no-write ops back to back, one retire per cycle in order
      for (int i = 0; i < 4; i++) begin
         push(6'(i + 20), 32'h300 + 32'(i), 10'h0, 9'h0, 1'b0, 1'b0, 1'b0);
         chk("t3_ret", out_retire_valid, 1);
         chk("t3_ret_pc", out_retire_pc, 32'h300 + 32'(i));
         chk("t3_stall", out_alu_stall, 0);
      end
      tick;
      chk("t3_idle", out_retire_valid, 0);

      // 4: fill with stalled VGPR ops, overflow on 5th push, drain
      for (int i = 0; i < 3; i++) begin
         push(6'(i + 1), 32'h400 + 32'(i), 10'h40 + 10'(i), 9'h0, 1'b1, 1'b0, 1'b0);
         chk("t4_stall", out_alu_stall, (i == 2) ? 1 : 0);
      end
      push(6'd4, 32'h403, 10'h43, 9'h0, 1'b1, 1'b0, 1'b0);
      chk("t4_ovf_4th", out_overflow, 0);
      push(6'd5, 32'h404, 10'h44, 9'h0, 1'b1, 1'b0, 1'b0);
      chk("t4_ovf_5th", out_overflow, 1);
      drain(12, nret);
      chk("t4_nret", nret, 4);
      for (int i = 0; i < 4; i++) chk("t4_order", ret_pc[i], 32'h400 + 32'(i));
      chk("t4_ovf_sticky", out_overflow, 1);
      chk("t4_unstall", out_alu_stall, 0);

      // 5: async reset with two entries pending
      push(6'd7, 32'h500, 10'h50, 9'h0, 1'b1, 1'b0, 1'b0);
      push(6'd8, 32'h501, 10'h51, 9'h0, 1'b1, 1'b0, 1'b0);
      chk("t5_vreq", out_vgpr_wr_req, 1);
      #3;
      rst = 1'b0;
      #1;
      chk("t5_async_vreq", out_vgpr_wr_req, 0);
      chk("t5_async_wfid", out_wr_wfid, 0);
      chk("t5_async_vaddr", out_vgpr_wr_addr, 0);
      chk("t5_async_ovf", out_overflow, 0);
      tick;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t5_noret", out_retire_valid, 0);
         chk("t5_novreq", out_vgpr_wr_req, 0);
         tick;
      end
      for (int i = 0; i < 3; i++) begin
         push(6'(i + 10), 32'h510 + 32'(i), 10'h0, 9'h0, 1'b1, 1'b0, 1'b0);
         chk("t5_cnt_stall", out_alu_stall, (i == 2) ? 1 : 0);
      end
      drain(10, nret);
      chk("t5_nret", nret, 3);
      chk("t5_ovf", out_overflow, 0);

      // 6: perf counters, 10 retires and 3 stall cycles
      do_reset;
      for (int i = 0; i < 7; i++) push(6'd1, 32'h600 + 32'(i), 10'h0, 9'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) push(6'd2, 32'h610 + 32'(i), 10'h0, 9'h0, 1'b1, 1'b0, 1'b0);
      chk("t6_stall", out_alu_stall, 1);
      tick;
      drain(10, nret);
      chk("t6_nret", nret, 3);
`ifdef ALU_WB_RETIRE_PERF_EN
      chk("t6_perf_ret", out_perf_retire_cnt, 10);
      chk("t6_perf_stall", out_perf_stall_cnt, 3);
`else
      chk("t6_perf_ret", out_perf_retire_cnt, 0);
      chk("t6_perf_stall", out_perf_stall_cnt, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
